// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
//
// Watches the segment bus and digit-select lines of a multiplexed N-digit
// 7-segment display and rebuilds the digits being shown as packed BCD.
// Each {segments, digit-select} pattern must be seen unchanged for STABLE_CYC
// consecutive samples before it is accepted. Patterns that are not a legal
// 0-9 glyph decode to 4'hF and raise the matching error bit. Once every digit
// has been captured, the frame is offered on a valid/ready output.
//
// Ports
//   clk          in   1        rising-edge clock
//   rst_n        in   1        asynchronous active-low reset
//   en_i         in   1        1 = collect frames, 0 = abandon the frame in progress
//   seg_i        in   7        segment levels, active-high, {a,b,c,d,e,f,g}
//   dig_sel_i    in   N_DIG    one-hot digit enable, bit 0 = rightmost digit
//   bcd_o        out  4*N_DIG  frame, nibble k = digit k (4'hF = illegal glyph)
//   err_o        out  N_DIG    bit k set = digit k was not a legal glyph
//   valid_o      out  1        frame available
//   ready_i      in   1        consumer takes the frame when valid_o && ready_i
//   frame_drop_o out  1        one-cycle pulse: a completed frame was discarded
// -----------------------------------------------------------------------------
module seg7_scan_decoder #(
    parameter int N_DIG      = 4,
    parameter int STABLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en_i,
    input  logic [6:0]           seg_i,
    input  logic [N_DIG-1:0]     dig_sel_i,
    output logic [4*N_DIG-1:0]   bcd_o,
    output logic [N_DIG-1:0]     err_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 frame_drop_o
);

    localparam int            CW      = (STABLE_CYC > 1) ? $clog2(STABLE_CYC) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
    // Count value one sample before acceptance: the capture edge is the one
    // on which the counter reaches CNT_MAX.
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYC - 2);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    // Returns {err, nibble} for a segment pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1111110:             r = {1'b0, 4'd0};
            7'b0110000:             r = {1'b0, 4'd1};
            7'b1101101:             r = {1'b0, 4'd2};
            7'b1111001:             r = {1'b0, 4'd3};
            7'b0110011:             r = {1'b0, 4'd4};
            7'b1011011:             r = {1'b0, 4'd5};
            7'b1011111, 7'b0011111: r = {1'b0, 4'd6};
            7'b1110000, 7'b1110010: r = {1'b0, 4'd7};
            7'b1111111:             r = {1'b0, 4'd8};
            7'b1111011, 7'b1110011: r = {1'b0, 4'd9};
            default:                r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    // ---------------------------------------------------------------- sampling
    logic [6:0]       seg_q;
    logic [N_DIG-1:0] sel_q;
    logic [CW-1:0]    cnt;
    logic             taken;     // this run has already produced its capture
    logic             same;
    logic             capture;

    // A blanking interval (no digit or several digits lit) never counts as stable.
    assign same    = (seg_i == seg_q) && (dig_sel_i == sel_q) && $onehot(dig_sel_i);
    assign capture = same && !taken && (cnt == CNT_PRE);

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            sel_q <= '0;
            cnt   <= '0;
            taken <= 1'b0;
        end else begin
            seg_q <= seg_i;
            sel_q <= dig_sel_i;
            if (same) begin
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                if (capture)        taken <= 1'b1;
            end else begin
                cnt   <= '0;
                taken <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- FSM
    state_t state_q, state_d;
    logic   abort;           // leaving COLLECT: throw away the partial frame

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_i) state_d = COLLECT;
            end
            COLLECT: begin
                if (!en_i) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- working buffer
    logic [4*N_DIG-1:0] work_bcd, work_bcd_upd;
    logic [N_DIG-1:0]   work_err, work_err_upd;
    logic [N_DIG-1:0]   captured, mask_next;
    logic [4:0]         dec;
    logic               capture_en;
    logic               frame_done;

    assign dec        = decode_glyph(seg_i);
    assign capture_en = capture && (state_q == COLLECT) && en_i;
    assign mask_next  = captured | dig_sel_i;
    assign frame_done = capture_en && (&mask_next);

    // Buffer contents with the digit being captured this edge already merged
    // in, so a completing frame reaches bcd_o on the capture edge itself.
    always_comb begin
        work_bcd_upd = work_bcd;
        work_err_upd = work_err;
        for (int k = 0; k < N_DIG; k++) begin
            if (dig_sel_i[k]) begin
                work_bcd_upd[4*k +: 4] = dec[3:0];
                work_err_upd[k]        = dec[4];
            end
        end
    end

    // NOTE: the working buffer is a small register file, not RAM, so it is
    // reset and cleared like any other state; stale digits never leak into a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_bcd <= '0;
            work_err <= '0;
            captured <= '0;
        end else if (abort) begin
            work_bcd <= '0;
            work_err <= '0;
            captured <= '0;
        end else if (capture_en) begin
            work_bcd <= work_bcd_upd;
            work_err <= work_err_upd;
            captured <= frame_done ? '0 : mask_next;
        end
    end

    // ---------------------------------------------------------------- output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_o        <= '0;
            err_o        <= '0;
            valid_o      <= 1'b0;
            frame_drop_o <= 1'b0;
        end else begin
            frame_drop_o <= frame_done && valid_o && !ready_i;
            if (frame_done && (!valid_o || ready_i)) begin
                bcd_o   <= work_bcd_upd;
                err_o   <= work_err_upd;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
//
// Directed bench for seg7_scan_decoder (N_DIG=4, STABLE_CYC=4). A reference
// model tracks run lengths, the glyph table and the frame/handshake rules;
// a compare process checks every DUT output against it on each falling edge.
// Literal expectations at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam int N  = 4;
    localparam int SC = 4;

    localparam logic [6:0] GLY [10] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
    };

    // Reference glyph table, alternates included.
    localparam logic [6:0] PATS [13] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
        7'b1011011, 7'b1011111, 7'b0011111, 7'b1110000, 7'b1110010,
        7'b1111111, 7'b1111011, 7'b1110011
    };
    localparam int VALS [13] = '{0, 1, 2, 3, 4, 5, 6, 6, 7, 7, 8, 9, 9};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en_i = 1'b0;
    logic [6:0]       seg_i = '0;
    logic [N-1:0]     dig_sel_i = '0;
    logic [4*N-1:0]   bcd_o;
    logic [N-1:0]     err_o;
    logic             valid_o;
    logic             ready_i = 1'b1;
    logic             frame_drop_o;

    int total = 0;
    int bad   = 0;

    seg7_scan_decoder #(.N_DIG(N), .STABLE_CYC(SC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .seg_i        (seg_i),
        .dig_sel_i    (dig_sel_i),
        .bcd_o        (bcd_o),
        .err_o        (err_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_drop_o (frame_drop_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int glyph_value(input logic [6:0] s);
        for (int i = 0; i < 13; i++)
            if (PATS[i] == s) return VALS[i];
        return -1;
    endfunction

    // ---------------------------------------------------------------- model
    logic [6:0]     m_prev_seg = '0;
    logic [N-1:0]   m_prev_sel = '0;
    int             m_run      = 0;   // consecutive samples of the current one-hot pattern
    bit             m_collect  = 0;
    bit [N-1:0]     m_mask     = '0;
    logic [3:0]     m_nib [N];
    bit             m_errb [N];
    logic [4*N-1:0] m_bcd      = '0;
    logic [N-1:0]   m_err      = '0;
    bit             m_valid    = 0;
    bit             m_drop     = 0;
    bit             m_done;
    bit             m_onehot;
    int             m_k;
    int             m_d;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_prev_seg = '0;
            m_prev_sel = '0;
            m_run      = 0;
            m_collect  = 0;
            m_mask     = '0;
            for (int i = 0; i < N; i++) begin m_nib[i] = '0; m_errb[i] = 0; end
            m_bcd   = '0;
            m_err   = '0;
            m_valid = 0;
            m_drop  = 0;
        end else begin
            m_onehot = ($countones(dig_sel_i) == 1);
            if (m_onehot && seg_i == m_prev_seg && dig_sel_i == m_prev_sel) m_run++;
            else m_run = m_onehot ? 1 : 0;
            m_prev_seg = seg_i;
            m_prev_sel = dig_sel_i;
            m_done = 0;
            m_drop = 0;
            if (!m_collect) begin
                if (en_i) m_collect = 1;
            end else if (!en_i) begin
                m_collect = 0;
                m_mask    = '0;
                for (int i = 0; i < N; i++) begin m_nib[i] = '0; m_errb[i] = 0; end
            end else if (m_run == SC) begin
                m_k = 0;
                for (int i = 0; i < N; i++) if (dig_sel_i[i]) m_k = i;
                m_d = glyph_value(seg_i);
                m_nib[m_k]  = (m_d < 0) ? 4'hF : 4'(m_d);
                m_errb[m_k] = (m_d < 0);
                m_mask[m_k] = 1;
                if (m_mask == '1) begin
                    m_done = 1;
                    m_mask = '0;
                end
            end
            if (m_done && (!m_valid || ready_i)) begin
                for (int i = 0; i < N; i++) begin
                    m_bcd[4*i +: 4] = m_nib[i];
                    m_err[i]        = m_errb[i];
                end
                m_valid = 1;
            end else if (m_done) begin
                m_drop = 1;
            end else if (m_valid && ready_i) begin
                m_valid = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("model bcd_o",        32'(bcd_o),        32'(m_bcd));
        check("model err_o",        32'(err_o),        32'(m_err));
        check("model valid_o",      32'(valid_o),      32'(m_valid));
        check("model frame_drop_o", 32'(frame_drop_o), 32'(m_drop));
    end

    // ---------------------------------------------------------------- stimulus
    task automatic hold(input logic [6:0] s, input logic [N-1:0] sel, input int n);
        seg_i     = s;
        dig_sel_i = sel;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Shows digits 0..2 for SC cycles each (digit 3 is left to the caller).
    task automatic scan3(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2);
        hold(g0, 4'b0001, SC);
        hold(g1, 4'b0010, SC);
        hold(g2, 4'b0100, SC);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #20 rst_n = 1'b1;
        #1;
        check("reset bcd_o",   32'(bcd_o),        32'h0);
        check("reset err_o",   32'(err_o),        32'h0);
        check("reset valid_o", 32'(valid_o),      32'h0);
        check("reset drop",    32'(frame_drop_o), 32'h0);

        // 1) "2,0,2,2", 6 cycles per digit, ready held high
        en_i    = 1'b1;
        ready_i = 1'b1;
        hold(7'h00, 4'b0000, 2);
        hold(GLY[2], 4'b0001, 6);
        hold(GLY[2], 4'b0010, 6);
        hold(GLY[0], 4'b0100, 6);
        hold(GLY[2], 4'b1000, 3);
        check("t1 valid before capture", 32'(valid_o), 32'h0);
        hold(GLY[2], 4'b1000, 1);
        check("t1 valid", 32'(valid_o), 32'h1);
        check("t1 bcd",   32'(bcd_o),   32'h2022);
        check("t1 err",   32'(err_o),   32'h0);
        hold(GLY[2], 4'b1000, 1);
        check("t1 valid one cycle", 32'(valid_o), 32'h0);
        hold(GLY[2], 4'b1000, 1);

        // 2) illegal glyph on digit 1, alternate 6/7/9 glyphs elsewhere
        scan3(7'b0011111, 7'b1001001, 7'b1110010);
        hold(7'b1110011, 4'b1000, SC);
        check("t2 valid", 32'(valid_o), 32'h1);
        check("t2 bcd",   32'(bcd_o),   32'h97F6);
        check("t2 err",   32'(err_o),   32'h2);
        hold(7'h00, 4'b0000, 1);

        // 3) glitch: 3-sample pattern is ignored, 4-sample pattern captured
        scan3(GLY[3], GLY[4], GLY[8]);
        hold(GLY[1], 4'b1000, 3);
        hold(GLY[5], 4'b1000, 3);
        check("t3 no early capture", 32'(valid_o), 32'h0);
        hold(GLY[5], 4'b1000, 1);
        check("t3 valid", 32'(valid_o), 32'h1);
        check("t3 bcd",   32'(bcd_o),   32'h5843);
        hold(7'h00, 4'b0000, 1);

        // 4) back-pressure: second frame is dropped, first held
        ready_i = 1'b0;
        scan3(GLY[1], GLY[2], GLY[3]);
        hold(GLY[4], 4'b1000, SC);
        check("t4 first valid", 32'(valid_o), 32'h1);
        check("t4 first bcd",   32'(bcd_o),   32'h4321);
        scan3(GLY[5], GLY[6], GLY[7]);
        hold(GLY[8], 4'b1000, SC);
        check("t4 drop pulse", 32'(frame_drop_o), 32'h1);
        check("t4 bcd held",   32'(bcd_o),        32'h4321);
        check("t4 valid held", 32'(valid_o),      32'h1);
        hold(GLY[8], 4'b1000, 1);
        check("t4 drop one cycle", 32'(frame_drop_o), 32'h0);
        ready_i = 1'b1;
        hold(7'h00, 4'b0000, 1);
        check("t4 accepted", 32'(valid_o), 32'h0);

        // 5) accept and load on the same edge
        ready_i = 1'b0;
        scan3(GLY[9], GLY[9], GLY[9]);
        hold(GLY[9], 4'b1000, SC);
        check("t5 first bcd", 32'(bcd_o), 32'h9999);
        scan3(GLY[0], GLY[1], GLY[0]);
        hold(GLY[1], 4'b1000, SC - 1);
        ready_i = 1'b1;
        hold(GLY[1], 4'b1000, 1);
        check("t5 valid stays", 32'(valid_o),      32'h1);
        check("t5 new bcd",     32'(bcd_o),        32'h1010);
        check("t5 no drop",     32'(frame_drop_o), 32'h0);
        hold(GLY[1], 4'b1000, 1);
        check("t5 accepted", 32'(valid_o), 32'h0);

        // 6) abort after two digits restarts the mask
        hold(GLY[3], 4'b0001, SC);
        hold(GLY[3], 4'b0010, SC);
        en_i = 1'b0;
        hold(7'h00, 4'b0000, 2);
        en_i = 1'b1;
        hold(7'h00, 4'b0000, 1);
        hold(GLY[7], 4'b0100, SC);
        hold(GLY[7], 4'b1000, SC);
        check("t6 no frame after abort", 32'(valid_o), 32'h0);
        hold(GLY[1], 4'b0001, SC);
        hold(GLY[2], 4'b0010, SC);
        check("t6 valid", 32'(valid_o), 32'h1);
        check("t6 bcd",   32'(bcd_o),   32'h7721);
        hold(7'h00, 4'b0000, 1);

        // 6b) asynchronous reset with a pending frame, mid-scan
        ready_i = 1'b0;
        scan3(GLY[1], GLY[1], GLY[1]);
        hold(GLY[1], 4'b1000, SC);
        check("t6b pending valid", 32'(valid_o), 32'h1);
        hold(GLY[2], 4'b0001, 2);
        #2 rst_n = 1'b0;
        #1;
        check("t6b async bcd",   32'(bcd_o),        32'h0);
        check("t6b async err",   32'(err_o),        32'h0);
        check("t6b async valid", 32'(valid_o),      32'h0);
        check("t6b async drop",  32'(frame_drop_o), 32'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        ready_i = 1'b1;
        hold(7'h00, 4'b0000, 1);
        scan3(GLY[4], GLY[3], GLY[2]);
        hold(GLY[1], 4'b1000, SC);
        check("t6b post-reset bcd", 32'(bcd_o), 32'h1234);
        hold(7'h00, 4'b0000, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
